// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754 binary32 multiplier with valid/ready handshake.
// Round-to-nearest-even only. Subnormals are flushed to zero on input and output.
// A shift-add loop consumes one multiplier bit per cycle, then normalise and round.
module fp_mul_seq #(
    parameter int MUL_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;

    localparam logic [4:0]        LAST_CNT = 5'(MUL_BITS - 1);
    localparam logic signed [9:0] BIAS     = 10'sd127;
    localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         result_q, result_d;
    logic [4:0]          flags_q, flags_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [47:0]         acc_q, acc_d;
    logic [47:0]         mcand_q, mcand_d;
    logic [23:0]         mplier_q, mplier_d;
    logic                sign_q, sign_d;
    logic signed [9:0]   ea_q, ea_d, eb_q, eb_d;
    logic signed [9:0]   exp_q, exp_d;
    logic [22:0]         mant_q, mant_d;
    logic                guard_q, guard_d;
    logic                sticky_q, sticky_d;
    logic                special_q, special_d;
    logic [31:0]         spec_res_q, spec_res_d;
    logic [4:0]          spec_flags_q, spec_flags_d;

    // Operand classification straight from the input fields
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic        in_sign;

    assign a_exp   = a[30:23];
    assign b_exp   = b[30:23];
    assign a_frac  = a[22:0];
    assign b_frac  = b[22:0];
    assign a_nan   = (&a_exp) && (|a_frac);
    assign b_nan   = (&b_exp) && (|b_frac);
    assign a_snan  = a_nan && !a_frac[22];
    assign b_snan  = b_nan && !b_frac[22];
    assign a_inf   = (&a_exp) && !(|a_frac);
    assign b_inf   = (&b_exp) && !(|b_frac);
    assign a_zero  = (a_exp == 8'd0);   // zero or subnormal (flushed)
    assign b_zero  = (b_exp == 8'd0);
    assign in_sign = a[31] ^ b[31];

    // Rounding arithmetic on the normalised mantissa
    logic              round_up;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp_rnd;

    assign round_up = guard_q && (sticky_q || mant_q[0]);
    assign mant_rnd = {1'b0, mant_q} + {23'd0, round_up};
    assign exp_rnd  = exp_q + (mant_rnd[23] ? 10'sd1 : 10'sd0);

    // Next-state and datapath computation for every stage of the sequence
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        sign_d       = sign_q;
        ea_d         = ea_q;
        eb_d         = eb_q;
        exp_d        = exp_q;
        mant_d       = mant_q;
        guard_d      = guard_q;
        sticky_d     = sticky_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_ready_d   = 1'b0;
                    sign_d       = in_sign;
                    ea_d         = $signed({2'b00, a_exp});
                    eb_d         = $signed({2'b00, b_exp});
                    mcand_d      = {24'd0, 1'b1, a_frac};
                    mplier_d     = {1'b1, b_frac};
                    acc_d        = 48'd0;
                    cnt_d        = 5'd0;
                    special_d    = 1'b1;
                    spec_flags_d = 5'b00000;
                    if (a_nan || b_nan) begin
                        spec_res_d   = QNAN;
                        spec_flags_d = {(a_snan || b_snan), 4'b0000};
                    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                        spec_res_d   = QNAN;
                        spec_flags_d = 5'b10000;
                    end else if (a_inf || b_inf) begin
                        spec_res_d = {in_sign, 8'hFF, 23'd0};
                    end else if (a_zero || b_zero) begin
                        spec_res_d = {in_sign, 31'd0};
                    end else begin
                        special_d  = 1'b0;
                        spec_res_d = 32'd0;
                    end
                    // Specials bypass the arithmetic and only take the output stage
                    state_d = (special_d) ? S_ROUND : S_MUL;
                end
            end
            S_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : 48'd0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 5'd0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_NORM: begin
                if (acc_q[47]) begin
                    exp_d    = ea_q + eb_q - BIAS + 10'sd1;
                    mant_d   = acc_q[46:24];
                    guard_d  = acc_q[23];
                    sticky_d = |acc_q[22:0];
                end else begin
                    exp_d    = ea_q + eb_q - BIAS;
                    mant_d   = acc_q[45:23];
                    guard_d  = acc_q[22];
                    sticky_d = |acc_q[21:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                out_valid_d = 1'b1;
                state_d     = S_DONE;
                if (special_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flags_q;
                end else if (exp_q <= 10'sd0) begin
                    // Underflow is decided on the pre-rounding exponent; no denormals
                    result_d = {sign_q, 31'd0};
                    flags_d  = 5'b00011;
                end else if (exp_rnd >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    flags_d  = 5'b00101;
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
                    flags_d  = {4'b0000, (guard_q || sticky_q)};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            result_q     <= 32'd0;
            flags_q      <= 5'd0;
            cnt_q        <= 5'd0;
            acc_q        <= 48'd0;
            mcand_q      <= 48'd0;
            mplier_q     <= 24'd0;
            sign_q       <= 1'b0;
            ea_q         <= 10'sd0;
            eb_q         <= 10'sd0;
            exp_q        <= 10'sd0;
            mant_q       <= 23'd0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            special_q    <= 1'b0;
            spec_res_q   <= 32'd0;
            spec_flags_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            sign_q       <= sign_d;
            ea_q         <= ea_d;
            eb_q         <= eb_d;
            exp_q        <= exp_d;
            mant_q       <= mant_d;
            guard_q      <= guard_d;
            sticky_q     <= sticky_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Testbench for fp_mul_seq: table of operand pairs with expected product, flags
// and latency, a scoreboard queue, plus backpressure and mid-operation reset.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Issue one operation, compare the scoreboard entry, optionally stall the consumer
    task automatic run_op(input vec_t v, input int hold);
        int   waited;
        int   lat;
        bit   seen;
        exp_t e;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        @(posedge clk);
        e.res = v.res;
        e.flg = v.flg;
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("latency", 32'(lat), 32'(v.lat));
        if (!seen) return;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("flags", 32'(flags), 32'(e.flg));
        $display("op %h * %h -> %h flags %02h latency %0d", v.a, v.b, result, flags, lat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, e.res);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[13];

    initial begin
        int vcount;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'h00, 26};
        vecs[1]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 5'h00, 26};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'h01, 26};
        vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'h10, 1};
        vecs[4]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1};
        vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00, 1};
        vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 5'h05, 26};
        vecs[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 5'h03, 26};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'h00, 1};
        vecs[9]  = '{32'h40400000, 32'h40400000, 32'h41100000, 5'h00, 26};
        vecs[10] = '{32'h3FC00001, 32'h3FC00000, 32'h40100001, 5'h01, 26};
        vecs[11] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 1};
        vecs[12] = '{32'h80000000, 32'h40A00000, 32'h80000000, 5'h00, 1};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        rst       = 1'b0;
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], 0);
        end

        // Backpressure: consumer stalls five cycles after the result appears
        run_op(vecs[0], 5);

        // Reset in the middle of the multiply loop
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h40400000;
        b        = 32'h40400000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", result, 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) vcount++;
        end
        check("midrst_no_result", 32'(vcount), 32'd0);
        $display("reset mid-operation: %0d spurious out_valid cycles", vcount);
        run_op(vecs[9], 0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 1000000");
        $fatal(1, "watchdog");
    end

endmodule
